// File: rtl/hs_pkg.sv
// Shared definitions for the req/ack dataflow fabric.
// Protocol: ack is a one-cycle pulse, and its payload is valid in that same cycle.
package hs_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_fifo_if.sv
// Handshake bundle for hs_fifo: upstream pull side (req_l/ack_l/din),
// downstream serve side (req_r/ack_r/dout), plus status.
interface hs_fifo_if
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic                  req_l;
  logic                  ack_l;
  logic [DATA_WIDTH-1:0] din;
  logic                  req_r;
  logic                  ack_r;
  logic [DATA_WIDTH-1:0] dout;
  logic [CNT_W-1:0]      count;
  logic                  overflow;

  modport master (
    input  req_l,
    output ack_l,
    output din,
    output req_r,
    input  ack_r,
    input  dout,
    input  count,
    input  overflow
  );

  modport slave (
    output req_l,
    input  ack_l,
    input  din,
    input  req_r,
    output ack_r,
    output dout,
    output count,
    output overflow
  );
endinterface

// File: rtl/hs_fifo_mem.sv
// Storage array for hs_fifo: one synchronous write port, one combinational read port.
module hs_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hs_fifo.sv
// Elastic buffer between a pulling upstream (req_l/ack_l) and a requesting
// downstream (req_r/ack_r); circular buffer with any depth in 2..256.
module hs_fifo
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic     clk,
  input  logic     rst,
  hs_fifo_if.slave bus
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DEPTH);
  // One slot stays reserved for an ack already in flight when req_l drops.
  localparam logic [CNT_W-1:0] CNT_REQ_MAX = CNT_W'(DEPTH - 2);

  logic [PTR_W-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  req_l_q, req_l_d;
  logic                  ack_r_q, ack_r_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  wr_s, rd_s;

  hs_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_W    (PTR_W)
  ) u_mem (
    .clk    (clk),
    .we_i   (wr_s),
    .waddr_i(wp_q),
    .wdata_i(bus.din),
    .raddr_i(rp_q),
    .rdata_o(rdata_s)
  );

  // Next-state for pointers, occupancy and handshake outputs.
  always_comb begin
    wr_s = bus.ack_l && (count_q < CNT_FULL);
    // Read uses pre-edge count: no same-edge bypass of a fresh write.
    rd_s = bus.req_r && !ack_r_q && (count_q != {CNT_W{1'b0}});

    wp_d = wp_q;
    if (wr_s) begin
      if (wp_q == PTR_LAST) begin
        wp_d = {PTR_W{1'b0}};
      end else begin
        wp_d = wp_q + 1'b1;
      end
    end else begin
      wp_d = wp_q;
    end

    rp_d = rp_q;
    if (rd_s) begin
      if (rp_q == PTR_LAST) begin
        rp_d = {PTR_W{1'b0}};
      end else begin
        rp_d = rp_q + 1'b1;
      end
    end else begin
      rp_d = rp_q;
    end

    case ({wr_s, rd_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    req_l_d    = (count_d <= CNT_REQ_MAX);
    ack_r_d    = rd_s;
    overflow_d = overflow_q | (bus.ack_l && (count_q == CNT_FULL));

    if (rd_s) begin
      dout_d = rdata_s;
    end else begin
      dout_d = dout_q;
    end
  end

  // State and registered outputs; synchronous reset discards all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= {PTR_W{1'b0}};
      rp_q       <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      req_l_q    <= 1'b0;
      ack_r_q    <= 1'b0;
      overflow_q <= 1'b0;
      dout_q     <= {DATA_WIDTH{1'b0}};
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      req_l_q    <= req_l_d;
      ack_r_q    <= ack_r_d;
      overflow_q <= overflow_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.req_l    = req_l_q;
  assign bus.ack_r    = ack_r_q;
  assign bus.dout     = dout_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_hs_fifo.sv
// Directed self-checking bench for hs_fifo at depths 4, 2 and 3.
module tb_hs_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hs_fifo_if #(.DATA_WIDTH(32), .DEPTH(4)) if4 ();
  hs_fifo_if #(.DATA_WIDTH(32), .DEPTH(2)) if2 ();
  hs_fifo_if #(.DATA_WIDTH(32), .DEPTH(3)) if3 ();

  hs_fifo #(.DATA_WIDTH(32), .DEPTH(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  hs_fifo #(.DATA_WIDTH(32), .DEPTH(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
  hs_fifo #(.DATA_WIDTH(32), .DEPTH(3)) u3 (.clk(clk), .rst(rst), .bus(if3));

  task automatic idle_inputs;
    if4.ack_l = 1'b0; if4.req_r = 1'b0; if4.din = 32'd0;
    if2.ack_l = 1'b0; if2.req_r = 1'b0; if2.din = 32'd0;
    if3.ack_l = 1'b0; if3.req_r = 1'b0; if3.din = 32'd0;
  endtask

  // Leaves the bench at a negedge with rst just released.
  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (if4.req_l !== 1'b0) begin errors++; $display("FAIL reset_req_l got %0b want 0", if4.req_l); end
    checks++; if (if4.ack_r !== 1'b0) begin errors++; $display("FAIL reset_ack_r got %0b want 0", if4.ack_r); end
    checks++; if (if4.dout !== 32'd0) begin errors++; $display("FAIL reset_dout got %h want 0", if4.dout); end
    checks++; if (if4.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", if4.count); end
    checks++; if (if4.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", if4.overflow); end
    checks++; if (u4.wp_q !== 2'd0 || u4.rp_q !== 2'd0) begin errors++; $display("FAIL reset_ptrs got wp=%0d rp=%0d want 0 0", u4.wp_q, u4.rp_q); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (if4.req_l !== 1'b1) begin errors++; $display("FAIL reset_req_rise got %0b want 1", if4.req_l); end
  endtask

  // Upstream answers one cycle after sampling req_l; consumer idle.
  task automatic test_first_write;
    logic [2:0] exp_cnt [8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    logic       exp_req [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic prev_req;
    int   d;
    prev_req = 1'b0;
    d = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (if4.count !== exp_cnt[k]) begin errors++; $display("FAIL first_count[%0d] got %0d want %0d", k, if4.count, exp_cnt[k]); end
      checks++; if (if4.req_l !== exp_req[k]) begin errors++; $display("FAIL first_req_l[%0d] got %0b want %0b", k, if4.req_l, exp_req[k]); end
      checks++; if (if4.overflow !== 1'b0) begin errors++; $display("FAIL first_overflow[%0d] got %0b want 0", k, if4.overflow); end
      if4.ack_l = prev_req;
      if4.din   = 32'(d);
      if (prev_req) d++;
      prev_req = if4.req_l;
    end
    if4.ack_l = 1'b0;
  endtask

  task automatic test_simultaneous;
    do_reset();
    if4.ack_l = 1'b1; if4.din = 32'h10;
    @(negedge clk);
    if4.din = 32'h11;
    @(negedge clk);
    checks++; if (if4.count !== 3'd2) begin errors++; $display("FAIL simul_preload_count got %0d want 2", if4.count); end
    checks++; if (u4.wp_q !== 2'd2 || u4.rp_q !== 2'd0) begin errors++; $display("FAIL simul_preload_ptrs got wp=%0d rp=%0d want 2 0", u4.wp_q, u4.rp_q); end
    if4.din = 32'h12; if4.req_r = 1'b1;
    @(negedge clk);
    if4.ack_l = 1'b0;
    checks++; if (if4.count !== 3'd2) begin errors++; $display("FAIL simul_count got %0d want 2", if4.count); end
    checks++; if (if4.ack_r !== 1'b1 || if4.dout !== 32'h10) begin errors++; $display("FAIL simul_read got ack=%0b dout=%h want 1 00000010", if4.ack_r, if4.dout); end
    checks++; if (u4.wp_q !== 2'd3 || u4.rp_q !== 2'd1) begin errors++; $display("FAIL simul_ptrs got wp=%0d rp=%0d want 3 1", u4.wp_q, u4.rp_q); end
    @(negedge clk);
    checks++; if (if4.ack_r !== 1'b0) begin errors++; $display("FAIL simul_pulse got %0b want 0", if4.ack_r); end
    @(negedge clk);
    checks++; if (if4.ack_r !== 1'b1 || if4.dout !== 32'h11) begin errors++; $display("FAIL simul_second got ack=%0b dout=%h want 1 00000011", if4.ack_r, if4.dout); end
    repeat (2) @(negedge clk);
    checks++; if (if4.ack_r !== 1'b1 || if4.dout !== 32'h12 || if4.count !== 3'd0) begin errors++; $display("FAIL simul_third got ack=%0b dout=%h cnt=%0d want 1 00000012 0", if4.ack_r, if4.dout, if4.count); end
    if4.req_r = 1'b0;
  endtask

  task automatic test_overflow;
    int rx;
    do_reset();
    if4.ack_l = 1'b1; if4.din = 32'd0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      if4.din = 32'(i);
    end
    @(negedge clk);
    checks++; if (if4.count !== 3'd4 || if4.overflow !== 1'b0) begin errors++; $display("FAIL ovf_full got cnt=%0d ovf=%0b want 4 0", if4.count, if4.overflow); end
    if4.din = 32'hAA;
    @(negedge clk);
    if4.ack_l = 1'b0;
    checks++; if (if4.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", if4.overflow); end
    checks++; if (if4.count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", if4.count); end
    if4.req_r = 1'b1;
    rx = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if4.ack_r) begin
        checks++; if (if4.dout !== 32'(rx)) begin errors++; $display("FAIL ovf_drain[%0d] got %h want %h", rx, if4.dout, rx); end
        rx++;
      end else if (rx > 0) begin
        checks++; if (if4.dout !== 32'(rx - 1)) begin errors++; $display("FAIL ovf_hold got %h want %h", if4.dout, rx - 1); end
      end
    end
    if4.req_r = 1'b0;
    checks++; if (rx != 4) begin errors++; $display("FAIL ovf_words got %0d want 4", rx); end
    checks++; if (if4.overflow !== 1'b1 || if4.count !== 3'd0) begin errors++; $display("FAIL ovf_sticky got ovf=%0b cnt=%0d want 1 0", if4.overflow, if4.count); end
    do_reset();
    @(negedge clk);
    checks++; if (if4.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", if4.overflow); end
  endtask

  task automatic test_reset_midstream;
    logic seen;
    do_reset();
    if4.ack_l = 1'b1; if4.din = 32'h20;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      if4.din = 32'h20 + 32'(i);
    end
    @(negedge clk);
    if4.ack_l = 1'b0; if4.req_r = 1'b1;
    @(negedge clk);
    checks++; if (if4.ack_r !== 1'b1 || if4.count !== 3'd3 || if4.dout !== 32'h20) begin errors++; $display("FAIL mid_pre got ack=%0b cnt=%0d dout=%h want 1 3 00000020", if4.ack_r, if4.count, if4.dout); end
    rst = 1'b1; if4.req_r = 1'b0;
    @(negedge clk);
    checks++; if (if4.ack_r !== 1'b0 || if4.dout !== 32'd0 || if4.count !== 3'd0) begin errors++; $display("FAIL mid_rst got ack=%0b dout=%h cnt=%0d want 0 0 0", if4.ack_r, if4.dout, if4.count); end
    rst = 1'b0;
    @(negedge clk);
    if4.ack_l = if4.req_l; if4.din = 32'h55;
    @(negedge clk);
    if4.ack_l = 1'b0; if4.req_r = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (if4.ack_r) begin
        seen = 1'b1;
        checks++; if (if4.dout !== 32'h55) begin errors++; $display("FAIL mid_first got %h want 00000055", if4.dout); end
      end
    end
    if4.req_r = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL mid_timeout got no ack_r want ack_r"); end
  endtask

  // Depth 2, same-cycle producer, always-ready consumer.
  task automatic test_back_to_back;
    int tx, rx, cyc, last, first_l;
    tx = 0; rx = 0; cyc = 0; last = 0; first_l = 0;
    do_reset();
    if2.req_r = 1'b1;
    while (rx < 5000 && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      if (if2.ack_r) begin
        checks++; if (if2.dout !== 32'(rx)) begin errors++; $display("FAIL pass_data[%0d] got %h want %h", rx, if2.dout, rx); end
        checks++;
        if (rx == 0) begin
          if (cyc != first_l + 2) begin errors++; $display("FAIL pass_latency got %0d want %0d", cyc - first_l, 2); end
        end else begin
          if (cyc - last != 2) begin errors++; $display("FAIL pass_gap[%0d] got %0d want 2", rx, cyc - last); end
        end
        last = cyc;
        rx++;
      end
      if2.ack_l = if2.req_l && (tx < 5000);
      if2.din   = 32'(tx);
      if (if2.ack_l) begin
        if (tx == 0) first_l = cyc;
        tx++;
      end
    end
    if2.ack_l = 1'b0; if2.req_r = 1'b0;
    checks++; if (rx != 5000) begin errors++; $display("FAIL pass_words got %0d want 5000", rx); end
    checks++; if (if2.overflow !== 1'b0) begin errors++; $display("FAIL pass_overflow got %0b want 0", if2.overflow); end
  endtask

  // Depth 3, producer answers one cycle late, consumer stalls after every other word.
  task automatic test_wrap;
    int   tx, rx, stall;
    logic prev_req;
    tx = 0; rx = 0; stall = 0; prev_req = 1'b0;
    do_reset();
    for (int c = 0; c < 400 && rx < 10; c++) begin
      @(negedge clk);
      checks++; if (if3.count > 2'd3) begin errors++; $display("FAIL wrap_count got %0d want <=3", if3.count); end
      if (if3.ack_r) begin
        checks++; if (if3.dout !== 32'(rx)) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", rx, if3.dout, rx); end
        rx++;
        if (rx % 2 == 1) stall = 4;
      end
      if3.req_r = (stall == 0);
      if (stall > 0) stall--;
      if3.ack_l = prev_req && (tx < 10);
      if3.din   = 32'(tx);
      if (if3.ack_l) tx++;
      prev_req = if3.req_l;
    end
    if3.ack_l = 1'b0; if3.req_r = 1'b0;
    checks++; if (rx != 10) begin errors++; $display("FAIL wrap_words got %0d want 10", rx); end
    checks++; if (if3.overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow got %0b want 0", if3.overflow); end
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_simultaneous();
    test_overflow();
    test_reset_midstream();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
